// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: default widths, controller state
// encoding and the Montgomery constant one.
package rsa_pkg;

   localparam int unsigned RSA_WIDTH = 32;
   localparam int unsigned RSA_LEN_W = 8;

   // Exponentiation controller states; each MM state has an issue and a wait phase.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CONV_M    = 3'd1,
      ST_CONV_ONE  = 3'd2,
      ST_MUL       = 3'd3,
      ST_SQR       = 3'd4,
      ST_NEXT      = 3'd5,
      ST_FROM_MONT = 3'd6,
      ST_FINISH    = 3'd7
   } exp_state_e;

   typedef enum logic {
      PH_ISSUE = 1'b0,
      PH_WAIT  = 1'b1
   } mm_phase_e;

   localparam logic [RSA_WIDTH-1:0] ONE = RSA_WIDTH'(1);

endpackage

// File: rtl/mod_exp_rl.sv
// Right-to-left binary modular exponentiation controller.
// Computes result = base^exponent mod modulus by sequencing an external
// Montgomery multiplier (R = 2^len) through its start/done handshake.
// Ports:
//   clk, rstn            clock, async active-low reset
//   start                one-cycle request, sampled only in IDLE
//   len, base, exponent, modulus, r2   operation inputs, latched on start
//   busy, done, result   status and final value
//   mm_start, mm_len, mm_a, mm_b, mm_mod   multiplier request side
//   mm_done, mm_out      multiplier completion side
module mod_exp_rl
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH = RSA_WIDTH,
   parameter int unsigned LEN_W = RSA_LEN_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   input  logic [WIDTH-1:0] r2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             mm_start,
   output logic [LEN_W-1:0] mm_len,
   output logic [WIDTH-1:0] mm_a,
   output logic [WIDTH-1:0] mm_b,
   output logic [WIDTH-1:0] mm_mod,
   input  logic             mm_done,
   input  logic [WIDTH-1:0] mm_out
);

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

   exp_state_e state_q, state_d;
   mm_phase_e  phase_q, phase_d;

   logic [LEN_W-1:0] len_q, len_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] mod_q, mod_d;
   logic [WIDTH-1:0] r2_q, r2_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [LEN_W-1:0] i_q, i_d;

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             mm_start_q, mm_start_d;
   logic [WIDTH-1:0] mm_a_q, mm_a_d;
   logic [WIDTH-1:0] mm_b_q, mm_b_d;

   logic             mm_done_q;
   logic             mm_edge_c;

   logic [WIDTH-1:0] op_a_c, op_b_c;
   logic [LEN_W-1:0] disp_idx_c;
   logic [WIDTH-1:0] exp_shift_c;
   logic             disp_bit_c;
   logic             disp_last_c;
   logic             last_c;
   exp_state_e       disp_st_c;

   // Rising-edge detector on mm_done; a held-high done is consumed once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mm_done_q <= 1'b0;
      end else begin
         mm_done_q <= mm_done;
      end
   end

   assign mm_edge_c = mm_done & ~mm_done_q;

   // Current bit index is the last scanned one (i >= len-1).
   assign last_c = ({1'b0, i_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};

   // Dispatch for the bit about to be scanned: index 0 after CONV_ONE, i+1 from NEXT.
   // Shifting out past WIDTH makes high-index bits read as zero.
   assign disp_idx_c  = (state_q == ST_NEXT) ? (i_q + LEN_W'(1)) : '0;
   assign exp_shift_c = exp_q >> disp_idx_c;
   assign disp_bit_c  = exp_shift_c[0];
   assign disp_last_c = ({1'b0, disp_idx_c} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
   assign disp_st_c   = disp_bit_c  ? ST_MUL :
                        disp_last_c ? ST_FROM_MONT : ST_SQR;

   // Operand selection for the multiplier call of the current state.
   always_comb begin
      op_a_c = '0;
      op_b_c = '0;
      case (state_q)
         ST_CONV_M:    begin op_a_c = base_q; op_b_c = r2_q;  end
         ST_CONV_ONE:  begin op_a_c = ONE_W;  op_b_c = r2_q;  end
         ST_MUL:       begin op_a_c = a_q;    op_b_c = z_q;   end
         ST_SQR:       begin op_a_c = z_q;    op_b_c = z_q;   end
         ST_FROM_MONT: begin op_a_c = a_q;    op_b_c = ONE_W; end
         default:      ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         phase_q <= PH_ISSUE;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CONV_M;
               phase_d = PH_ISSUE;
            end
         end
         ST_NEXT: begin
            state_d = disp_st_c;
            phase_d = PH_ISSUE;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            phase_d = PH_ISSUE;
         end
         default: begin
            if (phase_q == PH_ISSUE) begin
               phase_d = PH_WAIT;
            end else if (mm_edge_c) begin
               phase_d = PH_ISSUE;
               case (state_q)
                  ST_CONV_M:    state_d = ST_CONV_ONE;
                  ST_CONV_ONE:  state_d = (len_q == '0) ? ST_FROM_MONT : disp_st_c;
                  ST_MUL:       state_d = last_c ? ST_FROM_MONT : ST_SQR;
                  ST_SQR:       state_d = ST_NEXT;
                  ST_FROM_MONT: state_d = ST_FINISH;
                  default:      state_d = state_q;
               endcase
            end
         end
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      mm_start_d = 1'b0;
      mm_a_d     = mm_a_q;
      mm_b_d     = mm_b_q;
      len_d      = len_q;
      base_d     = base_q;
      exp_d      = exp_q;
      mod_d      = mod_q;
      r2_d       = r2_q;
      z_d        = z_q;
      a_d        = a_q;
      i_d        = i_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d  = len;
               base_d = base;
               exp_d  = exponent;
               mod_d  = modulus;
               r2_d   = r2;
               busy_d = 1'b1;
            end
         end
         ST_NEXT: begin
            i_d = disp_idx_c;
         end
         ST_FINISH: ;
         default: begin
            if (phase_q == PH_ISSUE) begin
               mm_start_d = 1'b1;
               mm_a_d     = op_a_c;
               mm_b_d     = op_b_c;
            end else if (mm_edge_c) begin
               case (state_q)
                  ST_CONV_M:   z_d = mm_out;
                  ST_CONV_ONE: begin
                     a_d = mm_out;
                     i_d = '0;
                  end
                  ST_MUL:      a_d = mm_out;
                  ST_SQR:      z_d = mm_out;
                  ST_FROM_MONT: begin
                     result_d = mm_out;
                     done_d   = 1'b1;
                     busy_d   = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         mm_start_q <= 1'b0;
         mm_a_q     <= '0;
         mm_b_q     <= '0;
         len_q      <= '0;
         base_q     <= '0;
         exp_q      <= '0;
         mod_q      <= '0;
         r2_q       <= '0;
         z_q        <= '0;
         a_q        <= '0;
         i_q        <= '0;
      end else begin
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
         mm_start_q <= mm_start_d;
         mm_a_q     <= mm_a_d;
         mm_b_q     <= mm_b_d;
         len_q      <= len_d;
         base_q     <= base_d;
         exp_q      <= exp_d;
         mod_q      <= mod_d;
         r2_q       <= r2_d;
         z_q        <= z_d;
         a_q        <= a_d;
         i_q        <= i_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign mm_start = mm_start_q;
   assign mm_a     = mm_a_q;
   assign mm_b     = mm_b_q;
   assign mm_len   = len_q;
   assign mm_mod   = mod_q;

endmodule

// File: tb/tb_mod_exp_rl.sv
// Testbench for mod_exp_rl: behavioural Montgomery multiplier beside the DUT,
// plain-arithmetic modular exponent reference, directed and random runs.
`timescale 1ns/1ps
module tb_mod_exp_rl;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned LEN_W = 8;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   logic [LEN_W-1:0] len;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] exponent;
   logic [WIDTH-1:0] modulus;
   logic [WIDTH-1:0] r2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             mm_start;
   logic [LEN_W-1:0] mm_len;
   logic [WIDTH-1:0] mm_a;
   logic [WIDTH-1:0] mm_b;
   logic [WIDTH-1:0] mm_mod;
   logic             mm_done;
   logic [WIDTH-1:0] mm_out;

   mod_exp_rl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .len      (len),
      .base     (base),
      .exponent (exponent),
      .modulus  (modulus),
      .r2       (r2),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .mm_start (mm_start),
      .mm_len   (mm_len),
      .mm_a     (mm_a),
      .mm_b     (mm_b),
      .mm_mod   (mm_mod),
      .mm_done  (mm_done),
      .mm_out   (mm_out)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Montgomery product x*y*2^-l mod n, by bitwise REDC on a wide integer.
   function automatic logic [31:0] mont(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] n, input logic [7:0] l);
      logic [127:0] t;
      t = 128'(x) * 128'(y);
      for (int k = 0; k < int'(l); k++) begin
         if (t[0]) t = t + 128'(n);
         t = t >> 1;
      end
      return 32'(t % 128'(n));
   endfunction

   // Plain square-and-multiply over the low l exponent bits.
   function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] n, input int l);
      logic [63:0] r, bb;
      r  = 64'(1) % 64'(n);
      bb = 64'(b) % 64'(n);
      for (int k = 0; k < l; k++) begin
         if (k < 32 && e[k]) r = (r * bb) % 64'(n);
         bb = (bb * bb) % 64'(n);
      end
      return 32'(r);
   endfunction

   function automatic logic [31:0] calc_r2(input logic [31:0] n, input int l);
      logic [63:0] r;
      r = 64'(1) % 64'(n);
      for (int k = 0; k < 2 * l; k++) r = (r << 1) % 64'(n);
      return 32'(r);
   endfunction

   function automatic int n_calls(input logic [31:0] e, input int l);
      int c;
      c = 3;
      for (int k = 0; k < l; k++) if (k < 32 && e[k]) c++;
      if (l > 0) c += l - 1;
      return c;
   endfunction

   // Multiplier model: random latency, done held for hold_cyc cycles, optional stray pulses.
   int          start_cnt = 0;
   int          hold_cyc  = 1;
   int          stray_req = 0;
   int          stray_ack = 0;
   int          hold_left = 0;
   int          calc_left = 0;
   bit          calc_pend = 1'b0;
   bit          dropped;
   logic [31:0] pend, sa, sb;

   always @(negedge clk) begin
      if (!rstn) begin
         mm_done   = 1'b0;
         mm_out    = '0;
         calc_pend = 1'b0;
         hold_left = 0;
      end else begin
         dropped = 1'b0;
         if (mm_done) begin
            if (hold_left > 0) hold_left--;
            else begin
               mm_done = 1'b0;
               dropped = 1'b1;
            end
         end
         if (mm_start) begin
            start_cnt++;
            pend      = mont(mm_a, mm_b, mm_mod, mm_len);
            sa        = mm_a;
            sb        = mm_b;
            calc_left = $urandom_range(4, 1);
            calc_pend = 1'b1;
         end else if (calc_pend) begin
            if (calc_left > 0) calc_left--;
            else if (!mm_done && !dropped) begin
               check_val("mm_operand_hold", {mm_a, mm_b}, {sa, sb});
               mm_done   = 1'b1;
               mm_out    = pend;
               hold_left = hold_cyc - 1;
               calc_pend = 1'b0;
            end
         end else if (stray_req != stray_ack && !mm_done && !dropped) begin
            stray_ack++;
            mm_done   = 1'b1;
            mm_out    = 32'hDEAD_BEEF;
            hold_left = 0;
         end
      end
   end

   int done_cnt = 0;
   always @(posedge clk) begin
      #2;
      if (done) done_cnt++;
   end

   task automatic run_exp(input string tag, input logic [31:0] b, input logic [31:0] e,
                          input logic [31:0] n, input logic [7:0] l, input logic [31:0] r,
                          input bit chk_res, input logic [31:0] exp_res,
                          input int exp_calls, input int inject_at);
      int s0, cyc;
      logic [31:0] res_at_done;
      tick();
      base = b; exponent = e; modulus = n; len = l; r2 = r; start = 1'b1;
      tick();
      start = 1'b0;
      check_val({tag, "_busy_rise"}, 64'(busy), 64'(1));
      s0 = start_cnt;
      done_cnt = 0;
      cyc = 0;
      while (!done && cyc < 4000) begin
         if (cyc == inject_at) begin
            start = 1'b1; base = 32'd3; exponent = 32'hFFFF; modulus = 32'd7;
            len = 8'd3; r2 = 32'd2;
         end
         tick();
         start = 1'b0;
         cyc++;
      end
      check_val({tag, "_done_seen"}, 64'(done), 64'(1));
      check_val({tag, "_busy_at_done"}, 64'(busy), 64'(0));
      res_at_done = result;
      if (chk_res) check_val({tag, "_result"}, 64'(result), 64'(exp_res));
      tick();
      tick();
      tick();
      check_val({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
      check_val({tag, "_busy_after"}, 64'(busy), 64'(0));
      check_val({tag, "_calls"}, 64'(start_cnt - s0), 64'(exp_calls));
      check_val({tag, "_result_held"}, 64'(result), 64'(res_at_done));
   endtask

   initial begin
      int cyc, s0, l;
      logic [31:0] n, b, e;
      rstn = 1'b0; start = 1'b0; len = '0; base = '0; exponent = '0;
      modulus = '0; r2 = '0;
      tick(); tick(); tick();
      check_val("rst_busy", 64'(busy), 64'(0));
      check_val("rst_done", 64'(done), 64'(0));
      check_val("rst_mm_start", 64'(mm_start), 64'(0));
      check_val("rst_result", 64'(result), 64'(0));
      check_val("rst_mm_ab", {mm_a, mm_b}, 64'(0));
      rstn = 1'b1;
      tick();

      run_exp("small", 32'd7, 32'd5, 32'd13, 8'd4, 32'd9, 1'b1, 32'd11, 8, -1);
      run_exp("zero_exp", 32'd7, 32'd0, 32'd13, 8'd4, 32'd9, 1'b1, 32'd1, 6, -1);
      run_exp("rsa", 32'd65, 32'd17, 32'd3233, 8'd12, 32'd1179, 1'b1, 32'd2790, 16, -1);
      run_exp("rsa_inject", 32'd65, 32'd17, 32'd3233, 8'd12, 32'd1179, 1'b1, 32'd2790, 16, 20);

      // Held done plus a stray done pulse while idle.
      hold_cyc = 3;
      done_cnt = 0;
      stray_req++;
      for (int k = 0; k < 6; k++) tick();
      check_val("stray_busy", 64'(busy), 64'(0));
      check_val("stray_done", 64'(done_cnt), 64'(0));
      run_exp("held", 32'd7, 32'd5, 32'd13, 8'd4, 32'd9, 1'b1, 32'd11, 8, -1);
      run_exp("held_rsa", 32'd65, 32'd17, 32'd3233, 8'd12, 32'd1179, 1'b1, 32'd2790, 16, -1);
      hold_cyc = 1;

      // len = 0 skips the scan; len beyond WIDTH still terminates.
      run_exp("len0", 32'd7, 32'd5, 32'd13, 8'd0, 32'd1, 1'b1, 32'd1, 3, -1);
      e = $urandom;
      run_exp("len40", 32'd7, e, 32'd13, 8'd40, calc_r2(32'd13, 40), 1'b0, 32'd0,
              n_calls(e, 40), -1);

      // Reset during the first squaring wait.
      tick();
      base = 32'd7; exponent = 32'd5; modulus = 32'd13; len = 8'd4; r2 = 32'd9; start = 1'b1;
      tick();
      start = 1'b0;
      s0 = start_cnt;
      cyc = 0;
      while (start_cnt < s0 + 4 && cyc < 500) begin
         tick();
         cyc++;
      end
      check_val("rst_mid_reach_sqr", 64'(start_cnt - s0), 64'(4));
      tick();
      rstn = 1'b0;
      #1;
      check_val("rst_mid_busy", 64'(busy), 64'(0));
      check_val("rst_mid_done", 64'(done), 64'(0));
      check_val("rst_mid_mm_start", 64'(mm_start), 64'(0));
      check_val("rst_mid_result", 64'(result), 64'(0));
      check_val("rst_mid_mm_ab", {mm_a, mm_b}, 64'(0));
      tick(); tick();
      rstn = 1'b1;
      tick();
      run_exp("after_rst", 32'd7, 32'd5, 32'd13, 8'd4, 32'd9, 1'b1, 32'd11, 8, -1);

      // Random operands against the reference exponentiation.
      for (int t = 0; t < 10; t++) begin
         l = $urandom_range(20, 2);
         n = $urandom_range((1 << l) - 1, 1 << (l - 1)) | 32'd1;
         b = $urandom % n;
         e = $urandom;
         hold_cyc = $urandom_range(3, 1);
         run_exp("rand", b, e, n, 8'(l), calc_r2(n, l), 1'b1, ref_pow(b, e, n, l),
                 n_calls(e, l), (t % 3 == 0) ? 15 : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
